// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RAM arbiter: access sizes, grant ids, FSM states.
// Pure definitions; no timing or flow-control behaviour of its own.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE,
        ST_REJECT
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check of one RAM access: size code, natural alignment, in-range.
// Zero latency; no flow control.
module mem_access_check
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 512
) (
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [1:0]            size,
    output logic                  ok
);

    logic [DATA_WIDTH:0] last_byte;
    logic                aligned;

    always_comb begin
        // One extra bit so an access near the top of the address space cannot wrap into range.
        last_byte = {1'b0, addr} + {{(DATA_WIDTH-2){1'b0}}, size_bytes(size)}
                    - (DATA_WIDTH+1)'(1);
        case (size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~addr[0];
            SIZE_WORD: aligned = (addr[1:0] == 2'b00);
            default:   aligned = 1'b0;
        endcase
        ok = aligned && (last_byte < (DATA_WIDTH+1)'(MEM_BYTES));
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin shares one RAM between fetch (I) and load/store (D); ack 2+STROBE_CYCLES cycles after grant, reject ack after 2.
// Requesters hold req and fields until their one-cycle ack; a new grant is only taken in IDLE.
module mem_arbiter_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_BYTES     = 512,
    parameter int STROBE_CYCLES = 1,
    parameter int FIRST_GRANT   = 0
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  iReq,
    input  logic [DATA_WIDTH-1:0] iAddr,
    output logic                  iAck,
    output logic                  iErr,
    output logic [DATA_WIDTH-1:0] iRdata,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [1:0]            dSize,
    input  logic                  dSigned,
    input  logic [DATA_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWdata,
    output logic                  dAck,
    output logic                  dErr,
    output logic [DATA_WIDTH-1:0] dRdata,
    output logic                  memWrite,
    output logic                  memRead,
    output logic [1:0]            sizeSignal,
    output logic [DATA_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  busy
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES);

    state_t                state;
    logic                  last_grant;
    logic                  gnt;
    logic                  we_q;
    logic                  signed_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt;

    logic                  ok;
    logic                  pick_i;
    logic                  bus_on;
    logic [DATA_WIDTH-1:0] load_data;

    mem_access_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_BYTES  (MEM_BYTES)
    ) u_check (
        .addr (addr_q),
        .size (size_q),
        .ok   (ok)
    );

    // On a tie, the port that did not win last time goes next.
    always_comb begin
        pick_i = iReq;
        if (iReq && dReq) begin
            pick_i = (last_grant == PORT_D);
        end
    end

    always_comb begin
        load_data = readData;
        case (size_q)
            SIZE_BYTE: load_data = signed_q ? {{(DATA_WIDTH-8){readData[7]}}, readData[7:0]}
                                            : {{(DATA_WIDTH-8){1'b0}}, readData[7:0]};
            SIZE_HALF: load_data = signed_q ? {{(DATA_WIDTH-16){readData[15]}}, readData[15:0]}
                                            : {{(DATA_WIDTH-16){1'b0}}, readData[15:0]};
            default:   load_data = readData;
        endcase
    end

    // Rejected accesses never put their address on the RAM bus.
    assign bus_on     = ((state == ST_SETUP) && ok) || (state == ST_STROBE) || (state == ST_DONE);
    assign address    = bus_on ? addr_q  : '0;
    assign writeData  = bus_on ? wdata_q : '0;
    assign sizeSignal = bus_on ? size_q  : 2'b00;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            last_grant <= (FIRST_GRANT != 0) ? PORT_D : PORT_I;
            gnt        <= PORT_D;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= SIZE_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= 4'd0;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            iAck       <= 1'b0;
            iErr       <= 1'b0;
            iRdata     <= '0;
            dAck       <= 1'b0;
            dErr       <= 1'b0;
            dRdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iReq || dReq) begin
                        gnt        <= pick_i ? PORT_I : PORT_D;
                        last_grant <= pick_i ? PORT_I : PORT_D;
                        addr_q     <= pick_i ? iAddr : dAddr;
                        size_q     <= pick_i ? SIZE_WORD : dSize;
                        we_q       <= !pick_i && dWe;
                        signed_q   <= !pick_i && dSigned;
                        wdata_q    <= pick_i ? '0 : dWdata;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (ok) begin
                        state    <= ST_STROBE;
                        memRead  <= !we_q;
                        memWrite <= we_q;
                        cnt      <= 4'd1;
                    end else begin
                        state <= ST_REJECT;
                        iAck  <= (gnt == PORT_I);
                        iErr  <= (gnt == PORT_I);
                        dAck  <= (gnt == PORT_D);
                        dErr  <= (gnt == PORT_D);
                    end
                end
                ST_STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        state    <= ST_DONE;
                        memRead  <= 1'b0;
                        memWrite <= 1'b0;
                        cnt      <= 4'd0;
                        iAck     <= (gnt == PORT_I);
                        dAck     <= (gnt == PORT_D);
                        if (gnt == PORT_I) begin
                            iRdata <= load_data;
                        end else begin
                            dRdata <= we_q ? '0 : load_data;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE, ST_REJECT: begin
                    state  <= ST_IDLE;
                    iAck   <= 1'b0;
                    iErr   <= 1'b0;
                    iRdata <= '0;
                    dAck   <= 1'b0;
                    dErr   <= 1'b0;
                    dRdata <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: vector table, corner sequences, random accesses vs. a byte-array model.
module tb_mem_arbiter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        iReq, dReq, dWe, dSigned;
    logic [1:0]  dSize;
    logic [31:0] iAddr, dAddr, dWdata;
    logic        iAck, iErr, dAck, dErr, memWrite, memRead, busy;
    logic [31:0] iRdata, dRdata, address, writeData, readData;
    logic [1:0]  sizeSignal;

    logic        iReq3;
    logic [31:0] iAddr3;
    logic        dReq3, dWe3, dSigned3;
    logic [1:0]  dSize3;
    logic [31:0] dAddr3, dWdata3;
    logic        iAck3, iErr3, dAck3, dErr3, memWrite3, memRead3, busy3;
    logic [31:0] iRdata3, dRdata3, address3, writeData3, readData3;
    logic [1:0]  sizeSignal3;

    mem_arbiter_ctrl #(.STROBE_CYCLES(1)) dut (
        .clk(clk), .resetN(resetN),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iErr(iErr), .iRdata(iRdata),
        .dReq(dReq), .dWe(dWe), .dSize(dSize), .dSigned(dSigned), .dAddr(dAddr), .dWdata(dWdata),
        .dAck(dAck), .dErr(dErr), .dRdata(dRdata),
        .memWrite(memWrite), .memRead(memRead), .sizeSignal(sizeSignal), .address(address),
        .writeData(writeData), .readData(readData), .busy(busy)
    );

    mem_arbiter_ctrl #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), .resetN(resetN),
        .iReq(iReq3), .iAddr(iAddr3), .iAck(iAck3), .iErr(iErr3), .iRdata(iRdata3),
        .dReq(dReq3), .dWe(dWe3), .dSize(dSize3), .dSigned(dSigned3), .dAddr(dAddr3), .dWdata(dWdata3),
        .dAck(dAck3), .dErr(dErr3), .dRdata(dRdata3),
        .memWrite(memWrite3), .memRead(memRead3), .sizeSignal(sizeSignal3), .address(address3),
        .writeData(writeData3), .readData(readData3), .busy(busy3)
    );

    assign readData3 = memRead3 ? 32'hCAFE_F00D : 32'h0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // RAM behind the SC=1 instance
    logic [7:0] ram [0:511];
    always @(posedge clk) begin
        if (memWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (k < nbytes(sizeSignal) && int'(address) + k < 512)
                    ram[int'(address) + k] <= writeData[8*k +: 8];
            end
        end
    end
    always_comb begin
        readData = 32'h0;
        if (memRead) begin
            for (int k = 0; k < 4; k++) begin
                if (k < nbytes(sizeSignal) && int'(address) + k < 512)
                    readData[8*k +: 8] = ram[int'(address) + k];
            end
        end
    end

    // Reference memory and access rules
    logic [7:0] mm [0:511];

    function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd);
        int n;
        longint v;
        n   = nbytes(sz);
        err = (sz == 2'd3) || ((a % n) != 0) || (longint'(a) + n > 512);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) mm[int'(a) + k] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (longint'(mm[int'(a) + k]) << (8*k));
                if (sg && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
                rd = v[31:0];
            end
        end
    endfunction

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            if (memRead && memWrite)              viol <= viol + 1;
            if ((memRead || memWrite) && !busy)   viol <= viol + 1;
            if (iAck && dAck)                     viol <= viol + 1;
            if (memRead3 && memWrite3)            viol <= viol + 1;
            if ((memRead3 || memWrite3) && !busy3) viol <= viol + 1;
        end
    end

    task automatic access(input logic isI, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd, output int lat,
                          output int wc, output int rc, output int other);
        @(negedge clk);
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        if (isI) begin
            iReq = 1'b1; iAddr = a;
        end else begin
            dReq = 1'b1; dWe = we; dSize = sz; dSigned = sg; dAddr = a; dWdata = wd;
        end
        lat = -1; wc = 0; rc = 0; other = 0; err = 1'b0; rd = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (memWrite) wc++;
            if (memRead)  rc++;
            if (isI ? dAck : iAck) other++;
            if (isI ? iAck : dAck) begin
                lat = c;
                err = isI ? iErr : dErr;
                rd  = isI ? iRdata : dRdata;
                break;
            end
        end
        iReq = 1'b0;
        dReq = 1'b0;
    endtask

    typedef struct {
        logic        isI;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t vt [20];

    initial begin
        logic        e, me;
        logic [31:0] r, mr;
        int          lat, wc, rc, other;
        int          order [4];
        int          ack_t [4];
        int          na;
        int          t1, t2, rc_first, rc_tot;

        vt[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h040, 32'hDEADBEEF, 1'b0, 32'h0,        3};
        vt[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0,        1'b0, 32'hDEADBEEF, 3};
        vt[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h050, 32'h12345680, 1'b0, 32'h0,        3};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h050, 32'h0,        1'b0, 32'hFFFFFF80, 3};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h050, 32'h0,        1'b0, 32'h00000080, 3};
        vt[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h060, 32'hAAAA8001, 1'b0, 32'h0,        3};
        vt[6]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h060, 32'h0,        1'b0, 32'hFFFF8001, 3};
        vt[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h060, 32'h0,        1'b0, 32'h00008001, 3};
        vt[8]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h042, 32'h0,        1'b1, 32'h0,        2};
        vt[9]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h041, 32'h0,        1'b1, 32'h0,        2};
        vt[10] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h040, 32'h0,        1'b1, 32'h0,        2};
        vt[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0,        1'b1, 32'h0,        2};
        vt[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h1FC, 32'h11223344, 1'b0, 32'h0,        3};
        vt[13] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'h11223344, 3};
        vt[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h1FE, 32'h55555555, 1'b1, 32'h0,        2};
        vt[15] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0,        1'b0, 32'hDEADBEEF, 3};
        vt[16] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h202, 32'h0,        1'b1, 32'h0,        2};
        vt[17] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h1FF, 32'h0,        1'b0, 32'h00000011, 3};
        vt[18] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h1FE, 32'h0,        1'b0, 32'h00001122, 3};
        vt[19] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0,        2};

        for (int k = 0; k < 512; k++) begin
            ram[k] = 8'h0;
            mm[k]  = 8'h0;
        end
        resetN = 1'b0;
        iReq = 0; iAddr = 0; dReq = 0; dWe = 0; dSize = 0; dSigned = 0; dAddr = 0; dWdata = 0;
        iReq3 = 0; iAddr3 = 32'h10; dReq3 = 0; dWe3 = 0; dSize3 = 0; dSigned3 = 0; dAddr3 = 0; dWdata3 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl bits", {25'd0, busy, memRead, memWrite, iAck, dAck, iErr, dErr}, 32'h0);
        chk("reset address", address, 32'h0);
        chk("reset writeData", writeData, 32'h0);
        chk("reset rdata", iRdata | dRdata | {30'd0, sizeSignal}, 32'h0);
        @(negedge clk) resetN = 1'b1;

        // Reset in the middle of a strobe
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b0; dSize = 2'd2; dAddr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset memRead", {31'd0, memRead}, 32'h1);
        @(negedge clk) resetN = 1'b0;
        @(posedge clk); #1;
        chk("abort memRead", {31'd0, memRead}, 32'h0);
        chk("abort busy/ack", {29'd0, busy, dAck, iAck}, 32'h0);
        chk("abort address", address, 32'h0);
        @(posedge clk); #1;
        chk("abort 2nd cycle", {29'd0, busy, dAck, memRead}, 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        dReq = 1'b0;

        // Tie right after reset: D first, then alternating while both are held
        @(negedge clk);
        iReq = 1'b1; iAddr = 32'h40;
        dReq = 1'b1; dWe = 1'b0; dSize = 2'd2; dSigned = 1'b0; dAddr = 32'h44;
        na = 0;
        for (int c = 1; c <= 60 && na < 4; c++) begin
            @(posedge clk); #1;
            if (dAck || iAck) begin
                order[na] = iAck ? 1 : 0;
                ack_t[na] = c;
                na++;
            end
        end
        iReq = 1'b0;
        dReq = 1'b0;
        chk("arb ack count", na, 4);
        for (int k = 0; k < na; k++)
            chk($sformatf("arb grant %0d (1=I)", k), order[k], (k % 2 == 0) ? 0 : 1);
        chk("arb first ack latency", (na > 0) ? ack_t[0] : -1, 3);
        if (na > 1) chk("arb ack spacing", ack_t[1] - ack_t[0], 4);

        // Directed vectors
        for (int i = 0; i < 20; i++) begin
            access(vt[i].isI, vt[i].we, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, e, r, lat, wc, rc, other);
            model(vt[i].we, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, me, mr);
            chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vt[i].err});
            chk($sformatf("vec%0d rdata", i), r, vt[i].rd);
            chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d write strobes", i), wc, (!vt[i].err && vt[i].we) ? 1 : 0);
            chk($sformatf("vec%0d read strobes", i), rc, (!vt[i].err && !vt[i].we) ? 1 : 0);
            chk($sformatf("vec%0d foreign ack", i), other, 0);
        end

        // Random accesses against the model
        for (int i = 0; i < 150; i++) begin
            logic        isI, we, sg;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            isI = ($urandom_range(0, 3) == 0);
            we  = !isI && ($urandom_range(0, 1) == 1);
            sz  = isI ? 2'd2 : 2'($urandom_range(0, 3));
            sg  = !isI && ($urandom_range(0, 1) == 1);
            a   = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 530));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            wd  = $urandom;
            model(we, sz, sg, a, wd, me, mr);
            access(isI, we, sz, sg, a, wd, e, r, lat, wc, rc, other);
            chk($sformatf("rnd%0d err", i), {31'd0, e}, {31'd0, me});
            chk($sformatf("rnd%0d rdata", i), r, mr);
            chk($sformatf("rnd%0d latency", i), lat, me ? 2 : 3);
            chk($sformatf("rnd%0d strobes", i), wc + rc, me ? 0 : 1);
        end

        // Three-cycle strobe with a held fetch request
        @(negedge clk);
        iReq3 = 1'b1;
        t1 = -1; t2 = -1; rc_first = 0; rc_tot = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (memRead3) rc_tot++;
            if (iAck3) begin
                if (t1 < 0) begin
                    t1 = c;
                    rc_first = rc_tot;
                    chk("sc3 fetch data", iRdata3, 32'hCAFE_F00D);
                end else begin
                    t2 = c;
                    break;
                end
            end
        end
        iReq3 = 1'b0;
        chk("sc3 first ack cycle", t1, 5);
        chk("sc3 strobe cycles", rc_first, 3);
        chk("sc3 ack spacing", (t2 < 0) ? -1 : t2 - t1, 6);
        chk("sc3 total strobe cycles", rc_tot, 6);

        repeat (3) @(posedge clk);
        #1;
        chk("protocol violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
